// File: rtl/dram_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: FSM state encoding and port-select constants.
package arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CPU_ACC  = 3'd1,
        CPU_DONE = 3'd2,
        EXT_ACC  = 3'd3,
        EXT_DONE = 3'd4
    } state_t;

    localparam logic SEL_CPU = 1'b0;
    localparam logic SEL_EXT = 1'b1;

endpackage

// File: rtl/dram_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; hit flags the saturation value.
module sat_counter #(
    parameter int unsigned width = 4,
    parameter int unsigned limit = 4
) (
    input  logic g_clk,
    input  logic g_clr,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam logic [width-1:0] LIM = limit[width-1:0];

    logic [width-1:0] r_count;

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != LIM)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign hit = (r_count == LIM);

endmodule

// File: rtl/dram_arbiter.sv
// Two-port (CPU / external loader) arbiter for a single-port data RAM, 2-cycle access.
// Define ARB_STARVE_GUARD_EN to bound consecutive CPU grants while the external port waits.
module dram_arbiter
    import arb_pkg::*;
#(
    parameter int a_width      = 8,
    parameter int d_width      = 8,
    parameter int starve_limit = 4
) (
    input  logic               g_clk,
    input  logic               g_clr,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [a_width-1:0] cpu_addr,
    input  logic [d_width-1:0] cpu_wdata,
    output logic [d_width-1:0] cpu_rdata,
    output logic               cpu_ack,
    output logic               stall,
    input  logic               ext_req,
    input  logic               ext_we,
    input  logic [a_width-1:0] ext_addr,
    input  logic [d_width-1:0] ext_wdata,
    output logic [d_width-1:0] ext_rdata,
    output logic               ext_ack,
    output logic [a_width-1:0] ram_addr,
    output logic [d_width-1:0] ram_wdata,
    output logic               ram_rd,
    output logic               ram_wr,
    input  logic [d_width-1:0] ram_rdata
);

    state_t             r_state;
    logic               r_sel;
    logic [a_width-1:0] r_ram_addr;
    logic [d_width-1:0] r_ram_wdata;
    logic               r_ram_rd;
    logic               r_ram_wr;
    logic               r_cpu_ack;
    logic               r_ext_ack;
    logic [d_width-1:0] r_cpu_rdata;
    logic [d_width-1:0] r_ext_rdata;

    logic w_arb;
    logic w_cpu_win;
    logic w_ext_win;
    logic w_starve_hit;

    assign w_arb     = (r_state == IDLE) || (r_state == CPU_DONE) || (r_state == EXT_DONE);
    assign w_cpu_win = w_arb && cpu_req && !w_starve_hit;
    assign w_ext_win = w_arb && ext_req && !w_cpu_win;

`ifdef ARB_STARVE_GUARD_EN
    sat_counter #(
        .width(4),
        .limit(starve_limit)
    ) u_starve (
        .g_clk(g_clk),
        .g_clr(g_clr),
        .inc  (w_cpu_win && ext_req),
        .clr  (w_ext_win || !ext_req),
        .hit  (w_starve_hit)
    );
`else
    // Zero for every legal starve_limit (1..15): strict CPU priority.
    assign w_starve_hit = (starve_limit == 0);
`endif

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_state     <= IDLE;
            r_sel       <= SEL_CPU;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_rd    <= 1'b0;
            r_ram_wr    <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_ext_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_ext_rdata <= '0;
        end else begin
            case (r_state)
                CPU_ACC, EXT_ACC: begin
                    r_ram_rd <= 1'b0;
                    r_ram_wr <= 1'b0;
                    // Read data is taken only for loads so a store leaves rdata untouched.
                    if (r_sel == SEL_CPU) begin
                        r_state   <= CPU_DONE;
                        r_cpu_ack <= 1'b1;
                        if (r_ram_rd) r_cpu_rdata <= ram_rdata;
                    end else begin
                        r_state   <= EXT_DONE;
                        r_ext_ack <= 1'b1;
                        if (r_ram_rd) r_ext_rdata <= ram_rdata;
                    end
                end
                default: begin
                    r_cpu_ack <= 1'b0;
                    r_ext_ack <= 1'b0;
                    if (w_cpu_win) begin
                        r_state     <= CPU_ACC;
                        r_sel       <= SEL_CPU;
                        r_ram_addr  <= cpu_addr;
                        r_ram_wdata <= cpu_wdata;
                        r_ram_rd    <= !cpu_we;
                        r_ram_wr    <= cpu_we;
                    end else if (w_ext_win) begin
                        r_state     <= EXT_ACC;
                        r_sel       <= SEL_EXT;
                        r_ram_addr  <= ext_addr;
                        r_ram_wdata <= ext_wdata;
                        r_ram_rd    <= !ext_we;
                        r_ram_wr    <= ext_we;
                    end else begin
                        r_state  <= IDLE;
                        r_ram_rd <= 1'b0;
                        r_ram_wr <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign cpu_ack   = r_cpu_ack;
    assign ext_rdata = r_ext_rdata;
    assign ext_ack   = r_ext_ack;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_rd    = r_ram_rd;
    assign ram_wr    = r_ram_wr;
    assign stall     = cpu_req && !r_cpu_ack;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: transaction-level reference model plus directed scenarios.
module tb_dram_arbiter;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int LIMIT = 4;

    logic       g_clk = 1'b0;
    logic       g_clr = 1'b1;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_addr = '0, cpu_wdata = '0;
    logic       ext_req = 1'b0, ext_we = 1'b0;
    logic [7:0] ext_addr = '0, ext_wdata = '0;
    logic [7:0] cpu_rdata, ext_rdata, ram_addr, ram_wdata, ram_rdata;
    logic       cpu_ack, ext_ack, stall, ram_rd, ram_wr;

    int vectors = 0;
    int miscompares = 0;
    bit run_cmp = 1'b0;

    dram_arbiter #(.a_width(8), .d_width(8), .starve_limit(LIMIT)) dut (
        .g_clk(g_clk), .g_clr(g_clr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .stall(stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_ack(ext_ack),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rd(ram_rd), .ram_wr(ram_wr),
        .ram_rdata(ram_rdata)
    );

    always #5 g_clk = ~g_clk;

    // RAM seen by the DUT: data at the strobed address is present by the end of the strobe cycle.
    logic [7:0] mem [256];
    assign ram_rdata = mem[ram_addr];
    always @(posedge g_clk) if (ram_wr) mem[ram_addr] <= ram_wdata;

    // Reference model: an access occupies the RAM for one cycle, completion is reported the next.
    logic [7:0] mem_model [256];
    bit         m_busy = 1'b0, m_owner_ext = 1'b0, m_we = 1'b0;
    logic [7:0] m_addr = '0, m_wdata = '0;
    int         m_cnt = 0;
    logic [7:0] e_cpu_rdata = '0, e_ext_rdata = '0, e_ram_addr = '0, e_ram_wdata = '0;
    bit         e_cpu_ack = 1'b0, e_ext_ack = 1'b0, e_ram_rd = 1'b0, e_ram_wr = 1'b0;

    always @(posedge g_clk or negedge g_clr) begin
        bit hit, cw, ew;
        if (!g_clr) begin
            m_busy = 1'b0; m_cnt = 0;
            e_cpu_rdata = '0; e_ext_rdata = '0; e_ram_addr = '0; e_ram_wdata = '0;
            e_cpu_ack = 1'b0; e_ext_ack = 1'b0; e_ram_rd = 1'b0; e_ram_wr = 1'b0;
        end else if (m_busy) begin
            m_busy = 1'b0;
            e_ram_rd = 1'b0; e_ram_wr = 1'b0;
            if (m_we) mem_model[m_addr] = m_wdata;
            if (m_owner_ext) begin
                e_ext_ack = 1'b1;
                if (!m_we) e_ext_rdata = mem_model[m_addr];
            end else begin
                e_cpu_ack = 1'b1;
                if (!m_we) e_cpu_rdata = mem_model[m_addr];
            end
            if (!ext_req) m_cnt = 0;
        end else begin
            e_cpu_ack = 1'b0; e_ext_ack = 1'b0;
            hit = GUARD && (m_cnt == LIMIT);
            cw = cpu_req && !hit;
            ew = !cw && ext_req;
            if (cw || ew) begin
                m_busy = 1'b1; m_owner_ext = ew;
                m_we    = cw ? cpu_we : ext_we;
                m_addr  = cw ? cpu_addr : ext_addr;
                m_wdata = cw ? cpu_wdata : ext_wdata;
                e_ram_addr = m_addr; e_ram_wdata = m_wdata;
                e_ram_rd = !m_we; e_ram_wr = m_we;
            end else begin
                e_ram_rd = 1'b0; e_ram_wr = 1'b0;
            end
            if (!ext_req || ew) m_cnt = 0;
            else if (cw && m_cnt < LIMIT) m_cnt = m_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        wait (run_cmp);
        forever begin
            @(posedge g_clk); #4;
            chk("cpu_rdata", cpu_rdata, e_cpu_rdata);
            chk("cpu_ack",   cpu_ack,   e_cpu_ack);
            chk("stall",     stall,     cpu_req && !e_cpu_ack);
            chk("ext_rdata", ext_rdata, e_ext_rdata);
            chk("ext_ack",   ext_ack,   e_ext_ack);
            chk("ram_addr",  ram_addr,  e_ram_addr);
            chk("ram_wdata", ram_wdata, e_ram_wdata);
            chk("ram_rd",    ram_rd,    e_ram_rd);
            chk("ram_wr",    ram_wr,    e_ram_wr);
            chk("rd_wr_excl",  ram_rd && ram_wr,   1'b0);
            chk("ack_excl",    cpu_ack && ext_ack, 1'b0);
        end
    end

    // One transaction on either port; lat = rising edges from request to ack, 0 on timeout.
    task automatic txn(input bit ext, input logic we, input logic [7:0] a, input logic [7:0] d,
                       output int lat, output int stalls);
        bit got = 1'b0;
        @(negedge g_clk);
        if (ext) begin ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d; end
        else     begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
        lat = 0;
        #1 stalls = int'(stall);
        for (int c = 1; c <= 10 && !got; c++) begin
            @(posedge g_clk); #4;
            if (stall) stalls++;
            if (ext ? ext_ack : cpu_ack) begin got = 1'b1; lat = c; end
        end
        @(negedge g_clk);
        if (ext) ext_req = 1'b0; else cpu_req = 1'b0;
    endtask

    initial begin
        int lat, stalls, n_cpu;
        bit got;
        for (int i = 0; i < 256; i++) begin mem[i] = '0; mem_model[i] = '0; end
        #2 g_clr = 1'b0;
        #1 run_cmp = 1'b1;
        chk("rst_ram_addr", ram_addr, 8'h00);
        chk("rst_cpu_rdata", cpu_rdata, 8'h00);
        chk("rst_strobes", {ram_rd, ram_wr, cpu_ack, ext_ack}, 4'b0000);
        repeat (2) @(negedge g_clk);
        g_clr = 1'b1;
        repeat (2) @(negedge g_clk);

        txn(1'b0, 1'b1, 8'h10, 8'hA5, lat, stalls);
        chk("cpu_store_lat", lat, 2);
        chk("cpu_store_stalls", stalls, 2);
        txn(1'b0, 1'b0, 8'h10, 8'h00, lat, stalls);
        chk("cpu_load_lat", lat, 2);
        chk("cpu_load_stalls", stalls, 2);
        chk("cpu_load_data", cpu_rdata, 8'hA5);

        // Both ports request together: CPU first, EXT at the CPU_DONE arbitration.
        @(negedge g_clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h11;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'h30; ext_wdata = 8'h22;
        got = 1'b0; lat = 0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(posedge g_clk); #4;
            if (ext_ack) begin got = 1'b1; lat = -1; end
            else if (cpu_ack) begin got = 1'b1; lat = c; end
        end
        chk("both_cpu_first_lat", lat, 2);
        @(negedge g_clk); cpu_req = 1'b0;
        got = 1'b0; lat = 0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(posedge g_clk); #4;
            if (ext_ack) begin got = 1'b1; lat = c; end
        end
        chk("both_ext_after_lat", lat, 2);
        @(negedge g_clk); ext_req = 1'b0;
        repeat (2) @(negedge g_clk);

        txn(1'b1, 1'b1, 8'hFF, 8'h3C, lat, stalls);
        chk("ext_store_lat", lat, 2);
        txn(1'b1, 1'b0, 8'hFF, 8'h00, lat, stalls);
        chk("ext_load_lat", lat, 2);
        chk("ext_load_data", ext_rdata, 8'h3C);
        chk("cpu_rdata_held", cpu_rdata, 8'hA5);

        // CPU requesting continuously with EXT waiting.
        @(negedge g_clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 8'h30;
        n_cpu = 0; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge g_clk); #4;
            if (cpu_ack) n_cpu++;
            if (ext_ack) got = 1'b1;
        end
        if (GUARD) begin
            chk("starve_cpu_grants", n_cpu, LIMIT);
            chk("starve_ext_granted", got, 1'b1);
            chk("starve_ext_data", ext_rdata, 8'h22);
        end else begin
            chk("strict_cpu_grants", n_cpu, 20);
            chk("strict_ext_granted", got, 1'b0);
        end
        @(negedge g_clk); ext_req = 1'b0;
        repeat (3) @(negedge g_clk);
        cpu_req = 1'b0;
        repeat (4) @(negedge g_clk);

        // Reset during a CPU access: aborted, outputs clear immediately.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
        @(posedge g_clk); #2;
        chk("acc_ram_rd_before_rst", ram_rd, 1'b1);
        g_clr = 1'b0; cpu_req = 1'b0;
        #1;
        chk("async_rst_ram_rd", ram_rd, 1'b0);
        chk("async_rst_ram_addr", ram_addr, 8'h00);
        chk("async_rst_cpu_rdata", cpu_rdata, 8'h00);
        chk("async_rst_ack", cpu_ack, 1'b0);
        repeat (2) @(negedge g_clk);

        // Release with a request pending: grant on the first rising edge.
        g_clr = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        @(posedge g_clk); #1;
        chk("first_edge_ram_rd", ram_rd, 1'b1);
        chk("first_edge_ram_addr", ram_addr, 8'h10);
        @(posedge g_clk); #1;
        chk("post_rst_ack", cpu_ack, 1'b1);
        chk("post_rst_data", cpu_rdata, 8'hA5);
        @(negedge g_clk); cpu_req = 1'b0;
        repeat (4) @(negedge g_clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
